// File: rtl/ramped_amplitude_scaler_pkg.sv
// Shared constants, FSM state encoding and channel-slice macro for the
// ramped amplitude scaler.
`ifndef RAMPED_AMPLITUDE_SCALER_PKG_SV
`define RAMPED_AMPLITUDE_SCALER_PKG_SV

// Bit range of channel k in a vector packed with w bits per channel.
`define RAS_CH_SLICE(k, w) (k)*(w) +: (w)

package ramped_amplitude_scaler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCALE   = 2'd1,
        ST_PUBLISH = 2'd2
    } ras_state_e;

    // Offset-binary code for silence.
    function automatic int unsigned midpoint_code(input int unsigned data_bits);
        return 32'd1 << (data_bits - 1);
    endfunction

    // Effective gain applied when the amplitude is all-ones and unity mapping is enabled.
    function automatic int unsigned unity_gain(input int unsigned amplitude_bits);
        return 32'd1 << amplitude_bits;
    endfunction

endpackage

`endif

// File: rtl/ramped_amplitude_scaler_amp_ramp_step.sv
// Combinational ramp limiter: moves an applied amplitude toward its target by at
// most RAMP_STEP, never overshooting and never wrapping.
module amp_ramp_step #(
    parameter int AMPLITUDE_BITS = 8,
    parameter int RAMP_STEP      = 4
) (
    input  logic [AMPLITUDE_BITS-1:0] applied,
    input  logic [AMPLITUDE_BITS-1:0] target,
    output logic [AMPLITUDE_BITS-1:0] next_applied
);

    localparam int AMP_MAX = (1 << AMPLITUDE_BITS) - 1;
    // A step wider than the full amplitude range behaves the same as the range itself.
    localparam logic [AMPLITUDE_BITS-1:0] STEP =
        AMPLITUDE_BITS'((RAMP_STEP > AMP_MAX) ? AMP_MAX : RAMP_STEP);

    logic                      rising;
    logic [AMPLITUDE_BITS-1:0] diff;

    always_comb begin
        rising = target > applied;
        diff   = rising ? (target - applied) : (applied - target);
        if (RAMP_STEP == 0 || diff <= STEP) begin
            next_applied = target;
        end else if (rising) begin
            next_applied = applied + STEP;
        end else begin
            next_applied = applied - STEP;
        end
    end

endmodule

// File: rtl/ramped_amplitude_scaler.sv
// Multi-channel offset-binary amplitude scaler with one shared multiplier and
// per-channel zipper-free amplitude ramping.
module ramped_amplitude_scaler
    import ramped_amplitude_scaler_pkg::*;
#(
    parameter int DATA_BITS      = 12,
    parameter int AMPLITUDE_BITS = 8,
    parameter int NUM_CHANNELS   = 4,
    parameter int RAMP_STEP      = 4,
    parameter int UNITY_AT_MAX   = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   sample_tick,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]      din,
    input  logic [NUM_CHANNELS*AMPLITUDE_BITS-1:0] amplitude,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]      dout,
    output logic                                   dout_valid,
    output logic                                   busy,
    output logic                                   overrun,
    input  logic                                   clear_overrun
);

    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PROD_W = DATA_BITS + AMPLITUDE_BITS + 2;
    localparam logic [DATA_BITS-1:0]      MID     = DATA_BITS'(midpoint_code(DATA_BITS));
    localparam logic [AMPLITUDE_BITS:0]   UNITY   = (AMPLITUDE_BITS+1)'(unity_gain(AMPLITUDE_BITS));
    localparam logic [CH_W-1:0]           LAST_CH = CH_W'(NUM_CHANNELS - 1);

    ras_state_e state, state_nxt;
    logic [CH_W-1:0] ch;
    logic load_snap, do_scale, do_publish;

    logic [DATA_BITS-1:0]      din_p0    [NUM_CHANNELS];
    logic [AMPLITUDE_BITS-1:0] tgt_p0    [NUM_CHANNELS];
    logic [AMPLITUDE_BITS-1:0] applied   [NUM_CHANNELS];
    logic [DATA_BITS-1:0]      result_p1 [NUM_CHANNELS];

    logic [DATA_BITS-1:0]      cur_din;
    logic [AMPLITUDE_BITS-1:0] cur_tgt, cur_app, app_nxt;
    logic [AMPLITUDE_BITS:0]   a_eff;
    logic signed [PROD_W-1:0]  sample_x, gain_x, product;
    logic [DATA_BITS-1:0]      scaled;

    function automatic logic signed [DATA_BITS-1:0] to_signed_sample(
        input logic [DATA_BITS-1:0] ob
    );
        return {~ob[DATA_BITS-1], ob[DATA_BITS-2:0]};
    endfunction

    // Floor division by 2^AMPLITUDE_BITS; the result always fits the sample range.
    function automatic logic [DATA_BITS-1:0] floor_to_offset(
        input logic signed [PROD_W-1:0] p
    );
        logic signed [PROD_W-1:0] r;
        r = p >>> AMPLITUDE_BITS;
        return {~r[DATA_BITS-1], r[DATA_BITS-2:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (sample_tick) state_nxt = ST_SCALE;
            ST_SCALE:   if (ch == LAST_CH) state_nxt = ST_PUBLISH;
            ST_PUBLISH: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        load_snap  = 1'b0;
        do_scale   = 1'b0;
        do_publish = 1'b0;
        case (state)
            ST_IDLE:    load_snap = sample_tick;
            ST_SCALE: begin
                busy     = 1'b1;
                do_scale = 1'b1;
            end
            ST_PUBLISH: begin
                busy       = 1'b1;
                do_publish = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch <= '0;
        end else if (load_snap) begin
            ch <= '0;
        end else if (do_scale) begin
            ch <= ch + CH_W'(1);
        end
    end

    // Stage p0: frame snapshot, isolated from input changes between ticks.
    always_ff @(posedge clk) begin
        if (load_snap) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                din_p0[k] <= din[`RAS_CH_SLICE(k, DATA_BITS)];
                tgt_p0[k] <= amplitude[`RAS_CH_SLICE(k, AMPLITUDE_BITS)];
            end
        end
    end

    always_comb begin
        cur_din  = din_p0[ch];
        cur_tgt  = tgt_p0[ch];
        cur_app  = applied[ch];
        a_eff    = (UNITY_AT_MAX != 0 && (&cur_app)) ? UNITY : {1'b0, cur_app};
        sample_x = PROD_W'(to_signed_sample(cur_din));
        gain_x   = PROD_W'(a_eff);
        product  = sample_x * gain_x;
        scaled   = floor_to_offset(product);
    end

    amp_ramp_step #(
        .AMPLITUDE_BITS(AMPLITUDE_BITS),
        .RAMP_STEP     (RAMP_STEP)
    ) u_ramp (
        .applied     (cur_app),
        .target      (cur_tgt),
        .next_applied(app_nxt)
    );

    // Stage p1: per-channel scaled result and ramped amplitude, one channel per cycle.
    always_ff @(posedge clk) begin
        if (do_scale) begin
            result_p1[ch] <= scaled;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                applied[k] <= '0;
            end
        end else if (do_scale) begin
            applied[ch] <= app_nxt;
        end
    end

    // Stage p2: publish the whole frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                dout[`RAS_CH_SLICE(k, DATA_BITS)] <= MID;
            end
            dout_valid <= 1'b0;
        end else begin
            if (do_publish) begin
                for (int k = 0; k < NUM_CHANNELS; k++) begin
                    dout[`RAS_CH_SLICE(k, DATA_BITS)] <= result_p1[k];
                end
            end
            dout_valid <= do_publish;
        end
    end

    // A tick during a frame takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (sample_tick && busy) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ramped_amplitude_scaler.sv
// Directed and randomized bench for ramped_amplitude_scaler (RAMP_STEP 0 and 16)
// and the standalone amp_ramp_step limiter.
module tb_ramped_amplitude_scaler;

    localparam int DB  = 12;
    localparam int AB  = 8;
    localparam int NC  = 4;
    localparam int MID = 1 << (DB - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sample_tick = 1'b0;
    logic clear_overrun = 1'b0;
    logic [NC*DB-1:0] din = '0;
    logic [NC*AB-1:0] amplitude = '0;

    logic [NC*DB-1:0] dout_a, dout_b;
    logic dv_a, dv_b, busy_a, busy_b, ovr_a, ovr_b;
    logic [AB-1:0] ra, rt, rn;

    int n_cmp = 0;
    int n_bad = 0;
    int app_a [NC];
    int app_b [NC];
    logic [NC*DB-1:0] exp_a, exp_b;
    logic [NC*DB-1:0] all_mid;

    always #5 clk = ~clk;

    ramped_amplitude_scaler #(.DATA_BITS(DB), .AMPLITUDE_BITS(AB), .NUM_CHANNELS(NC),
                              .RAMP_STEP(0), .UNITY_AT_MAX(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .din(din),
        .amplitude(amplitude), .dout(dout_a), .dout_valid(dv_a), .busy(busy_a),
        .overrun(ovr_a), .clear_overrun(clear_overrun));

    ramped_amplitude_scaler #(.DATA_BITS(DB), .AMPLITUDE_BITS(AB), .NUM_CHANNELS(NC),
                              .RAMP_STEP(16), .UNITY_AT_MAX(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .din(din),
        .amplitude(amplitude), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b),
        .overrun(ovr_b), .clear_overrun(clear_overrun));

    amp_ramp_step #(.AMPLITUDE_BITS(AB), .RAMP_STEP(16)) u_ramp_chk (
        .applied(ra), .target(rt), .next_applied(rn));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: gain = amplitude/2^AB (all-ones means exactly 1), floor rounding.
    function automatic int scale_ref(input int d, input int a);
        int s, g, p;
        s = d - MID;
        g = (a == (1 << AB) - 1) ? (1 << AB) : a;
        p = s * g;
        if (p >= 0) return MID + p / (1 << AB);
        return MID - ((-p + (1 << AB) - 1) / (1 << AB));
    endfunction

    function automatic int ramp_ref(input int a, input int t, input int step);
        if (step == 0) return t;
        if (t > a) return (a + step < t) ? a + step : t;
        if (t < a) return (a - step > t) ? a - step : t;
        return a;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            app_a[k] = 0;
            app_b[k] = 0;
        end
        exp_a = all_mid;
        exp_b = all_mid;
    endtask

    task automatic model_frame(input logic [NC*DB-1:0] d, input logic [NC*AB-1:0] a);
        int dk, tk;
        for (int k = 0; k < NC; k++) begin
            dk = int'(d[k*DB +: DB]);
            tk = int'(a[k*AB +: AB]);
            exp_a[k*DB +: DB] = DB'(scale_ref(dk, app_a[k]));
            exp_b[k*DB +: DB] = DB'(scale_ref(dk, app_b[k]));
            app_a[k] = ramp_ref(app_a[k], tk, 0);
            app_b[k] = ramp_ref(app_b[k], tk, 16);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        sample_tick = 1'b0;
        clear_overrun = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One accepted frame: tick, wait for dout_valid (bounded), compare everything.
    task automatic run_frame(input logic [NC*DB-1:0] d, input logic [NC*AB-1:0] a,
                             input string tag);
        int cnt;
        din = d;
        amplitude = a;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        model_frame(d, a);
        din = (NC*DB)'({$urandom(), $urandom()});
        amplitude = $urandom();
        cnt = 0;
        while (!dv_a && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, " latency"}, 64'(cnt), 64'(NC + 1));
        check({tag, " valid_b"}, 64'(dv_b), 64'd1);
        check({tag, " dout_a"}, 64'(dout_a), 64'(exp_a));
        check({tag, " dout_b"}, 64'(dout_b), 64'(exp_b));
        @(posedge clk); #1;
        check({tag, " valid_drop"}, 64'(dv_a), 64'd0);
        check({tag, " busy_done"}, 64'(busy_a), 64'd0);
    endtask

    initial begin
        logic [NC*DB-1:0] d;
        logic [NC*AB-1:0] a;
        logic [NC*DB-1:0] got;
        int pulses;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC*DB-1:0] d;
        logic [NC*AB-1:0] a;
        logic [NC*DB-1:0] got;
        int pulses;

        for (int k = 0; k < NC; k++) all_mid[k*DB +: DB] = DB'(MID);

        // Reset state
        do_reset();
        idle(2);
        check("reset dout_a", 64'(dout_a), 64'(all_mid));
        check("reset dout_b", 64'(dout_b), 64'(all_mid));
        check("reset valid", 64'(dv_a), 64'd0);
        check("reset busy", 64'(busy_a), 64'd0);
        check("reset overrun", 64'(ovr_b), 64'd0);

        // Immediate amplitude: first frame silent, second scaled
        d = {12'hC00, 12'h800, 12'h000, 12'hFFF};
        a = {8'd0, 8'd77, 8'd128, 8'd255};
        run_frame(d, a, "jump f1");
        check("jump f1 silent", 64'(dout_a), 64'(all_mid));
        run_frame(d, a, "jump f2");
        check("jump f2 direct", 64'(dout_a), 64'({12'h800, 12'h800, 12'h400, 12'hFFF}));

        // Ramp up on ch0 toward 40 in steps of 16, ticks every 10 cycles
        do_reset();
        d = {12'h800, 12'h800, 12'h800, 12'hFFF};
        a = {8'd0, 8'd0, 8'd0, 8'd40};
        run_frame(d, a, "up1"); check("up1 ch0", 64'(dout_b[11:0]), 64'h800); idle(3);
        run_frame(d, a, "up2"); check("up2 ch0", 64'(dout_b[11:0]), 64'h87F); idle(3);
        run_frame(d, a, "up3"); check("up3 ch0", 64'(dout_b[11:0]), 64'h8FF); idle(3);
        run_frame(d, a, "up4"); check("up4 ch0", 64'(dout_b[11:0]), 64'h93F); idle(3);
        run_frame(d, a, "up5"); check("up5 ch0", 64'(dout_b[11:0]), 64'h93F); idle(3);

        // Settle at 255, then ramp down to 0 without wrapping
        a = {8'd0, 8'd0, 8'd0, 8'd255};
        for (int i = 0; i < 15; i++) run_frame(d, a, "settle");
        a = {8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(d, a, "down0");
        check("down first unity", 64'(dout_b[11:0]), 64'hFFF);
        for (int i = 0; i < 17; i++) run_frame(d, a, "down");
        check("down floor", 64'(dout_b[11:0]), 64'h800);

        // Overrun: second tick two cycles after the first is ignored
        d = {12'h123, 12'h456, 12'h789, 12'hABC};
        a = {8'd200, 8'd100, 8'd255, 8'd50};
        din = d; amplitude = a; sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        model_frame(d, a);
        @(posedge clk); #1;
        din = ~d; amplitude = ~a; sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        pulses = 0; got = '0;
        repeat (10) begin
            @(posedge clk); #1;
            if (dv_a) begin
                pulses++;
                got = dout_a;
            end
        end
        check("ovr pulses", 64'(pulses), 64'd1);
        check("ovr snapshot", 64'(got), 64'(exp_a));
        check("ovr dout_b", 64'(dout_b), 64'(exp_b));
        check("ovr flag_a", 64'(ovr_a), 64'd1);
        check("ovr flag_b", 64'(ovr_b), 64'd1);
        clear_overrun = 1'b1;
        @(posedge clk); #1;
        clear_overrun = 1'b0;
        check("ovr cleared", 64'(ovr_a), 64'd0);

        // Set and clear in the same cycle: set wins
        din = d; amplitude = a; sample_tick = 1'b1;
        @(posedge clk); #1;
        model_frame(d, a);
        clear_overrun = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        clear_overrun = 1'b0;
        check("ovr set wins", 64'(ovr_a), 64'd1);
        idle(8);
        check("ovr2 dout_a", 64'(dout_a), 64'(exp_a));
        clear_overrun = 1'b1;
        @(posedge clk); #1;
        clear_overrun = 1'b0;

        // Reset in the middle of a frame
        din = {12'hFFF, 12'hFFF, 12'h000, 12'h000};
        amplitude = {8'd255, 8'd255, 8'd255, 8'd255};
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst dout_a", 64'(dout_a), 64'(all_mid));
        check("midrst dout_b", 64'(dout_b), 64'(all_mid));
        check("midrst busy", 64'(busy_a), 64'd0);
        check("midrst valid", 64'(dv_a), 64'd0);
        idle(3);
        rst_n = 1'b1;
        model_reset();
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (dv_a || dv_b) pulses++;
        end
        check("midrst no valid", 64'(pulses), 64'd0);
        run_frame({12'hFFF, 12'h000, 12'h555, 12'hAAA}, {8'd255, 8'd255, 8'd255, 8'd255}, "post rst");

        // Randomized frames with idle gaps
        for (int i = 0; i < 20; i++) begin
            d = (NC*DB)'({$urandom(), $urandom()});
            a = $urandom();
            if ($urandom_range(0, 3) == 0) a[7:0] = 8'hFF;
            run_frame(d, a, "rand");
            idle($urandom_range(0, 3));
        end

        // Ramp limiter standalone
        ra = 8'd5;   rt = 8'd0;   #1 check("ramp no wrap", 64'(rn), 64'd0);
        ra = 8'd0;   rt = 8'd255; #1 check("ramp up step", 64'(rn), 64'd16);
        ra = 8'd250; rt = 8'd255; #1 check("ramp up clamp", 64'(rn), 64'd255);
        ra = 8'd100; rt = 8'd100; #1 check("ramp hold", 64'(rn), 64'd100);
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom());
            rt = 8'($urandom());
            #1 check("ramp rand", 64'(rn), 64'(ramp_ref(int'(ra), int'(rt), 16)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
